// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] opb_p0;
  logic            div_p0;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shl_hi;
  logic [XLEN:0]   trial;

  // Multiply: hi:lo shifts right, lo holds the multiplier. Divide: hi is the
  // partial remainder, lo shifts the dividend out and the quotient in.
  always_comb begin
    add_sum = {1'b0, hi} + {1'b0, opb_p0};
    mul_sum = lo[0] ? add_sum : {1'b0, hi};
    shl_hi  = {hi, lo[XLEN-1]};
    trial   = shl_hi - {1'b0, opb_p0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      opb_p0 <= '0;
      div_p0 <= 1'b0;
    end else if (load) begin
      hi     <= '0;
      lo     <= op_a;
      opb_p0 <= op_b;
      div_p0 <= div_mode;
    end else if (step) begin
      if (div_p0) begin
        if (!trial[XLEN]) begin
          hi <= trial[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= shl_hi[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, iteration counter, special cases and sign fix-up.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      f3_p0;
  logic            neg_q_p0;
  logic            neg_r_p0;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf, special, issue;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] dp_hi, dp_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] fix_res;

  // Issue-time decode: signedness, magnitudes and the bypass cases
  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && src_a[XLEN-1];
    b_neg    = b_signed && src_b[XLEN-1];
    a_mag    = cond_neg(a_neg, src_a);
    b_mag    = cond_neg(b_neg, src_b);
    is_div   = funct3[2];
    div_zero = is_div && (src_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    special  = div_zero || div_ovf;
    issue    = (state == ST_IDLE) && start && !flush;
    if (div_zero)
      special_res = funct3[1] ? src_a : '1;
    else
      special_res = funct3[1] ? '0 : src_a;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (issue && !special),
    .step     (state == ST_CALC),
    .div_mode (is_div),
    .op_a     (a_mag),
    .op_b     (b_mag),
    .hi       (dp_hi),
    .lo       (dp_lo)
  );

  // Fix-up stage: signs restored on magnitudes, then half/quotient/remainder select
  always_comb begin
    prod_fix = cond_neg2(neg_q_p0, {dp_hi, dp_lo});
    case (f3_p0)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = cond_neg(neg_q_p0, dp_lo);
      default:                      fix_res = cond_neg(neg_r_p0, dp_hi);
    endcase
  end

  assign stall = (start && (state == ST_IDLE)) || (state == ST_CALC) || (state == ST_FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      f3_p0    <= '0;
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            f3_p0    <= funct3;
            neg_q_p0 <= a_neg ^ b_neg;
            neg_r_p0 <= a_neg;
            busy     <= 1'b1;
            if (special) begin
              result <= special_res;
              state  <= ST_DONE;
              done   <= 1'b1;
            end else begin
              cnt   <= CNT_W'(XLEN);
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            result <= fix_res;
            state  <= ST_DONE;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
